// File: rtl/ats21_cmd_arbiter_if.sv
// Client command/response handshakes and the ATS21 req/ctrl/stat lanes,
// bundled so the arbiter and its clients share one connection point.
interface ats21_cmd_arbiter_if;
    logic        cmdA_valid;
    logic [31:0] cmdA_data;
    logic        cmdA_ready;
    logic        cmdB_valid;
    logic [31:0] cmdB_data;
    logic        cmdB_ready;
    logic        respA_valid;
    logic        respA_ack;
    logic        respB_valid;
    logic        respB_ack;
    logic        req_o;
    logic [15:0] ctrlA_o;
    logic [15:0] ctrlB_o;
    logic [1:0]  stat_i;
    logic        busy;

    modport slave (
        input  cmdA_valid, cmdA_data, cmdB_valid, cmdB_data, stat_i,
        output cmdA_ready, cmdB_ready, respA_valid, respA_ack,
               respB_valid, respB_ack, req_o, ctrlA_o, ctrlB_o, busy
    );

    modport master (
        output cmdA_valid, cmdA_data, cmdB_valid, cmdB_data, stat_i,
        input  cmdA_ready, cmdB_ready, respA_valid, respA_ack,
               respB_valid, respB_ack, req_o, ctrlA_o, ctrlB_o, busy
    );
endinterface

// File: rtl/ats21_cmd_arbiter.sv
// Two-client command arbiter for the ATS21 timer core: pairs compatible
// instructions onto lanes A/B, serializes conflicts round-robin, relays stat.
module ats21_cmd_arbiter #(
    parameter int unsigned STAT_LAT = 1
) (
    input  logic               clk_1x,
    input  logic               reset,
    ats21_cmd_arbiter_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_BEAT0, S_BEAT1, S_WAIT, S_RESP} state_t;

    localparam logic [2:0] WAIT_INIT = 3'(STAT_LAT - 1);

    function automatic logic is_valid_op(input logic [2:0] op);
        return !(op == 3'b000 || op == 3'b100);
    endfunction

    function automatic logic is_clock(input logic [2:0] op);
        return (op == 3'b001 || op == 3'b010);
    endfunction

    function automatic logic is_alarm(input logic [2:0] op);
        return (op == 3'b101 || op == 3'b110 || op == 3'b111);
    endfunction

    // Invalid opcodes fall in no class, so they can never conflict.
    function automatic logic conflict(input logic [31:0] a, input logic [31:0] b);
        return (is_clock(a[31:29]) && is_clock(b[31:29]) && a[28:25] == b[28:25]) ||
               (is_alarm(a[31:29]) && is_alarm(b[31:29]) && a[28:24] == b[28:24]) ||
               (a[31:29] == 3'b011 && b[31:29] == 3'b011);
    endfunction

    state_t      state_q, state_d;
    logic        rr_q, rr_d;
    logic [31:0] cmdA_q, cmdA_d, cmdB_q, cmdB_d;
    logic        selA_q, selA_d, selB_q, selB_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic [15:0] ctrlA_q, ctrlA_d, ctrlB_q, ctrlB_d;
    logic        respA_valid_q, respA_valid_d, respB_valid_q, respB_valid_d;
    logic        respA_ack_q, respA_ack_d, respB_ack_q, respB_ack_d;
    logic        busy_q, busy_d;
    logic        sel_a, sel_b, conf;

    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        cmdA_d        = cmdA_q;
        cmdB_d        = cmdB_q;
        selA_d        = selA_q;
        selB_d        = selB_q;
        cnt_d         = cnt_q;
        req_d         = 1'b0;
        ctrlA_d       = 16'h0;
        ctrlB_d       = 16'h0;
        respA_valid_d = 1'b0;
        respB_valid_d = 1'b0;
        respA_ack_d   = respA_ack_q;
        respB_ack_d   = respB_ack_q;
        sel_a         = 1'b0;
        sel_b         = 1'b0;
        conf          = bus.cmdA_valid && bus.cmdB_valid && conflict(bus.cmdA_data, bus.cmdB_data);

        case (state_q)
            S_IDLE: begin
                // Ready is withheld while reset is held so no client sees a phantom accept.
                sel_a = !reset && bus.cmdA_valid && (!conf || !rr_q);
                sel_b = !reset && bus.cmdB_valid && (!conf || rr_q);
                if (sel_a || sel_b) begin
                    state_d = S_BEAT0;
                    rr_d    = rr_q ^ conf;
                    selA_d  = sel_a;
                    selB_d  = sel_b;
                    // Invalid or unselected lanes are latched as zero so they drive 0.
                    cmdA_d  = (sel_a && is_valid_op(bus.cmdA_data[31:29])) ? bus.cmdA_data : 32'h0;
                    cmdB_d  = (sel_b && is_valid_op(bus.cmdB_data[31:29])) ? bus.cmdB_data : 32'h0;
                    req_d   = 1'b1;
                    ctrlA_d = cmdA_d[31:16];
                    ctrlB_d = cmdB_d[31:16];
                end
            end
            S_BEAT0: begin
                state_d = S_BEAT1;
                req_d   = 1'b0;
                req_d   = 1'b1;
                ctrlA_d = cmdA_q[15:0];
                ctrlB_d = cmdB_q[15:0];
            end
            S_BEAT1: begin
                state_d = S_WAIT;
                cnt_d   = WAIT_INIT;
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d       = S_RESP;
                    respA_valid_d = selA_q;
                    respB_valid_d = selB_q;
                    if (selA_q) respA_ack_d = bus.stat_i[0] && is_valid_op(cmdA_q[31:29]);
                    if (selB_q) respB_ack_d = bus.stat_i[1] && is_valid_op(cmdB_q[31:29]);
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                selA_d  = 1'b0;
                selB_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_1x or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            rr_q          <= 1'b0;
            cmdA_q        <= 32'h0;
            cmdB_q        <= 32'h0;
            selA_q        <= 1'b0;
            selB_q        <= 1'b0;
            cnt_q         <= 3'd0;
            req_q         <= 1'b0;
            ctrlA_q       <= 16'h0;
            ctrlB_q       <= 16'h0;
            respA_valid_q <= 1'b0;
            respB_valid_q <= 1'b0;
            respA_ack_q   <= 1'b0;
            respB_ack_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_q          <= rr_d;
            cmdA_q        <= cmdA_d;
            cmdB_q        <= cmdB_d;
            selA_q        <= selA_d;
            selB_q        <= selB_d;
            cnt_q         <= cnt_d;
            req_q         <= req_d;
            ctrlA_q       <= ctrlA_d;
            ctrlB_q       <= ctrlB_d;
            respA_valid_q <= respA_valid_d;
            respB_valid_q <= respB_valid_d;
            respA_ack_q   <= respA_ack_d;
            respB_ack_q   <= respB_ack_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.cmdA_ready  = sel_a;
    assign bus.cmdB_ready  = sel_b;
    assign bus.req_o       = req_q;
    assign bus.ctrlA_o     = ctrlA_q;
    assign bus.ctrlB_o     = ctrlB_q;
    assign bus.respA_valid = respA_valid_q;
    assign bus.respB_valid = respB_valid_q;
    assign bus.respA_ack   = respA_ack_q;
    assign bus.respB_ack   = respB_ack_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_ats21_cmd_arbiter.sv
// Directed bench for ats21_cmd_arbiter: one DUT with STAT_LAT=1, one with STAT_LAT=3.
module tb_ats21_cmd_arbiter;
    logic clk_1x = 1'b0;
    logic reset  = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk_1x = ~clk_1x;

    ats21_cmd_arbiter_if b1();
    ats21_cmd_arbiter_if b3();

    ats21_cmd_arbiter #(.STAT_LAT(1)) dut  (.clk_1x(clk_1x), .reset(reset), .bus(b1.slave));
    ats21_cmd_arbiter #(.STAT_LAT(3)) dut3 (.clk_1x(clk_1x), .reset(reset), .bus(b3.slave));

    task automatic tick;
        @(posedge clk_1x);
        #1;
    endtask

    task automatic sample;
        @(negedge clk_1x);
    endtask

    task automatic idle_inputs;
        b1.cmdA_valid = 1'b0; b1.cmdA_data = 32'h0; b1.cmdB_valid = 1'b0; b1.cmdB_data = 32'h0; b1.stat_i = 2'b00;
        b3.cmdA_valid = 1'b0; b3.cmdA_data = 32'h0; b3.cmdB_valid = 1'b0; b3.cmdB_data = 32'h0; b3.stat_i = 2'b00;
    endtask

    task automatic do_reset;
        tick;
        reset = 1'b1;
        idle_inputs();
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        tick;
        reset = 1'b1;
        idle_inputs();
        b1.cmdA_valid = 1'b1;
        b1.cmdA_data  = 32'h2200_1234;
        sample;
        checks++;
        if ({b1.cmdA_ready, b1.cmdB_ready, b1.respA_valid, b1.respA_ack, b1.respB_valid, b1.respB_ack,
             b1.req_o, b1.busy, b1.ctrlA_o, b1.ctrlB_o} !== 40'h0) begin
            failures++;
            $display("FAIL reset_outputs_l1: ready=%b%b req=%b busy=%b ctrlA=%h ctrlB=%h, all required 0",
                     b1.cmdA_ready, b1.cmdB_ready, b1.req_o, b1.busy, b1.ctrlA_o, b1.ctrlB_o);
        end
        checks++;
        if ({b3.cmdA_ready, b3.cmdB_ready, b3.respA_valid, b3.respA_ack, b3.respB_valid, b3.respB_ack,
             b3.req_o, b3.busy, b3.ctrlA_o, b3.ctrlB_o} !== 40'h0) begin
            failures++;
            $display("FAIL reset_outputs_l3: req=%b busy=%b ctrlA=%h ctrlB=%h, all required 0",
                     b3.req_o, b3.busy, b3.ctrlA_o, b3.ctrlB_o);
        end
        tick;
        b1.cmdA_valid = 1'b0;
        reset = 1'b0;
        sample;
        checks++;
        if ({b1.req_o, b1.busy, b1.respA_valid, b1.respA_ack} !== 4'b0) begin
            failures++;
            $display("FAIL after_reset_idle: req=%b busy=%b rvA=%b ackA=%b, required 0", b1.req_o, b1.busy,
                     b1.respA_valid, b1.respA_ack);
        end
    endtask

    task automatic test_single;
        do_reset();
        tick;
        b1.cmdA_valid = 1'b1; b1.cmdA_data = 32'h2200_1234;
        sample;
        checks++;
        if ({b1.cmdA_ready, b1.cmdB_ready} !== 2'b10) begin
            failures++; $display("FAIL single_ready: got %b%b required 10", b1.cmdA_ready, b1.cmdB_ready);
        end
        tick;
        b1.cmdA_valid = 1'b0;
        sample;
        checks++;
        if ({b1.req_o, b1.busy, b1.ctrlA_o, b1.ctrlB_o} !== {2'b11, 16'h2200, 16'h0000}) begin
            failures++; $display("FAIL single_beat0: req=%b busy=%b ctrlA=%h ctrlB=%h required 1 1 2200 0000",
                                 b1.req_o, b1.busy, b1.ctrlA_o, b1.ctrlB_o);
        end
        tick;
        sample;
        checks++;
        if ({b1.req_o, b1.ctrlA_o, b1.ctrlB_o} !== {1'b1, 16'h1234, 16'h0000}) begin
            failures++; $display("FAIL single_beat1: req=%b ctrlA=%h ctrlB=%h required 1 1234 0000",
                                 b1.req_o, b1.ctrlA_o, b1.ctrlB_o);
        end
        tick;
        b1.stat_i = 2'b01;
        sample;
        checks++;
        if ({b1.req_o, b1.ctrlA_o, b1.ctrlB_o, b1.respA_valid} !== 34'h0) begin
            failures++; $display("FAIL single_wait: req=%b ctrlA=%h ctrlB=%h rvA=%b required all 0",
                                 b1.req_o, b1.ctrlA_o, b1.ctrlB_o, b1.respA_valid);
        end
        tick;
        b1.stat_i = 2'b00;
        sample;
        checks++;
        if ({b1.respA_valid, b1.respA_ack, b1.respB_valid, b1.busy} !== 4'b1101) begin
            failures++; $display("FAIL single_resp: rvA=%b ackA=%b rvB=%b busy=%b required 1 1 0 1",
                                 b1.respA_valid, b1.respA_ack, b1.respB_valid, b1.busy);
        end
        tick;
        sample;
        checks++;
        if ({b1.respA_valid, b1.respA_ack, b1.busy} !== 3'b010) begin
            failures++; $display("FAIL single_after: rvA=%b ackA(held)=%b busy=%b required 0 1 0",
                                 b1.respA_valid, b1.respA_ack, b1.busy);
        end
    endtask

    task automatic test_paired;
        do_reset();
        tick;
        b1.cmdA_valid = 1'b1; b1.cmdA_data = 32'h2200_0000;
        b1.cmdB_valid = 1'b1; b1.cmdB_data = 32'hA300_0010;
        sample;
        checks++;
        if ({b1.cmdA_ready, b1.cmdB_ready} !== 2'b11) begin
            failures++; $display("FAIL paired_ready: got %b%b required 11", b1.cmdA_ready, b1.cmdB_ready);
        end
        tick;
        b1.cmdA_valid = 1'b0; b1.cmdB_valid = 1'b0;
        sample;
        checks++;
        if ({b1.req_o, b1.ctrlA_o, b1.ctrlB_o} !== {1'b1, 16'h2200, 16'hA300}) begin
            failures++; $display("FAIL paired_beat0: req=%b ctrlA=%h ctrlB=%h required 1 2200 a300",
                                 b1.req_o, b1.ctrlA_o, b1.ctrlB_o);
        end
        tick;
        sample;
        checks++;
        if ({b1.req_o, b1.ctrlA_o, b1.ctrlB_o} !== {1'b1, 16'h0000, 16'h0010}) begin
            failures++; $display("FAIL paired_beat1: req=%b ctrlA=%h ctrlB=%h required 1 0000 0010",
                                 b1.req_o, b1.ctrlA_o, b1.ctrlB_o);
        end
        tick;
        b1.stat_i = 2'b11;
        tick;
        b1.stat_i = 2'b00;
        sample;
        checks++;
        if ({b1.respA_valid, b1.respA_ack, b1.respB_valid, b1.respB_ack} !== 4'b1111) begin
            failures++; $display("FAIL paired_resp: rvA=%b ackA=%b rvB=%b ackB=%b required 1111",
                                 b1.respA_valid, b1.respA_ack, b1.respB_valid, b1.respB_ack);
        end
        tick;
    endtask

    task automatic test_conflict_rr;
        do_reset();
        b1.stat_i = 2'b11;
        tick;
        b1.cmdA_valid = 1'b1; b1.cmdA_data = 32'hA500_0020;
        b1.cmdB_valid = 1'b1; b1.cmdB_data = 32'hC500_0030;
        sample;
        checks++;
        if ({b1.cmdA_ready, b1.cmdB_ready} !== 2'b10) begin
            failures++; $display("FAIL conflict_first_ready: got %b%b required 10", b1.cmdA_ready, b1.cmdB_ready);
        end
        tick;
        b1.cmdA_valid = 1'b0;
        sample;
        checks++;
        if ({b1.cmdB_ready, b1.ctrlA_o, b1.ctrlB_o} !== {1'b0, 16'hA500, 16'h0000}) begin
            failures++; $display("FAIL conflict_first_beat0: readyB=%b ctrlA=%h ctrlB=%h required 0 a500 0000",
                                 b1.cmdB_ready, b1.ctrlA_o, b1.ctrlB_o);
        end
        tick; tick; tick;
        sample;
        checks++;
        if ({b1.respA_valid, b1.respB_valid, b1.cmdB_ready} !== 3'b100) begin
            failures++; $display("FAIL conflict_first_resp: rvA=%b rvB=%b readyB=%b required 1 0 0",
                                 b1.respA_valid, b1.respB_valid, b1.cmdB_ready);
        end
        tick;
        b1.cmdA_valid = 1'b1; b1.cmdA_data = 32'hA500_0020;
        sample;
        checks++;
        if ({b1.cmdA_ready, b1.cmdB_ready} !== 2'b01) begin
            failures++; $display("FAIL conflict_second_ready: got %b%b required 01", b1.cmdA_ready, b1.cmdB_ready);
        end
        tick;
        b1.cmdB_valid = 1'b0;
        sample;
        checks++;
        if ({b1.ctrlA_o, b1.ctrlB_o} !== {16'h0000, 16'hC500}) begin
            failures++; $display("FAIL conflict_second_beat0: ctrlA=%h ctrlB=%h required 0000 c500",
                                 b1.ctrlA_o, b1.ctrlB_o);
        end
        tick; tick; tick;
        sample;
        checks++;
        if ({b1.respA_valid, b1.respB_valid, b1.respB_ack} !== 3'b011) begin
            failures++; $display("FAIL conflict_second_resp: rvA=%b rvB=%b ackB=%b required 0 1 1",
                                 b1.respA_valid, b1.respB_valid, b1.respB_ack);
        end
        tick;
        b1.cmdB_valid = 1'b1; b1.cmdB_data = 32'hC500_0030;
        sample;
        checks++;
        if ({b1.cmdA_ready, b1.cmdB_ready} !== 2'b10) begin
            failures++; $display("FAIL conflict_third_ready: got %b%b required 10", b1.cmdA_ready, b1.cmdB_ready);
        end
        tick;
        b1.cmdA_valid = 1'b0; b1.cmdB_valid = 1'b0; b1.stat_i = 2'b00;
        repeat (5) tick;
    endtask

    task automatic test_class_rules;
        logic [31:0] da [3] = '{32'h2200_0000, 32'h6000_0000, 32'hA200_0000};
        logic [31:0] db [3] = '{32'h4300_0000, 32'h6100_0000, 32'h2200_0000};
        logic [1:0]  rdy [3] = '{2'b10, 2'b01, 2'b11};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick;
            b1.cmdA_valid = 1'b1; b1.cmdA_data = da[i];
            b1.cmdB_valid = 1'b1; b1.cmdB_data = db[i];
            sample;
            checks++;
            if ({b1.cmdA_ready, b1.cmdB_ready} !== rdy[i]) begin
                failures++; $display("FAIL class_rule_%0d: ready=%b%b required %b", i, b1.cmdA_ready,
                                     b1.cmdB_ready, rdy[i]);
            end
            tick;
            b1.cmdA_valid = 1'b0; b1.cmdB_valid = 1'b0;
            repeat (3) tick;
        end
    endtask

    task automatic test_invalid;
        do_reset();
        tick;
        b1.cmdA_valid = 1'b1; b1.cmdA_data = 32'h8000_0000;
        b1.cmdB_valid = 1'b1; b1.cmdB_data = 32'h4400_5678;
        sample;
        checks++;
        if ({b1.cmdA_ready, b1.cmdB_ready} !== 2'b11) begin
            failures++; $display("FAIL invalid_ready: got %b%b required 11", b1.cmdA_ready, b1.cmdB_ready);
        end
        tick;
        b1.cmdA_valid = 1'b0; b1.cmdB_valid = 1'b0;
        sample;
        checks++;
        if ({b1.req_o, b1.ctrlA_o, b1.ctrlB_o} !== {1'b1, 16'h0000, 16'h4400}) begin
            failures++; $display("FAIL invalid_beat0: req=%b ctrlA=%h ctrlB=%h required 1 0000 4400",
                                 b1.req_o, b1.ctrlA_o, b1.ctrlB_o);
        end
        tick;
        sample;
        checks++;
        if ({b1.ctrlA_o, b1.ctrlB_o} !== {16'h0000, 16'h5678}) begin
            failures++; $display("FAIL invalid_beat1: ctrlA=%h ctrlB=%h required 0000 5678", b1.ctrlA_o, b1.ctrlB_o);
        end
        tick;
        b1.stat_i = 2'b11;
        tick;
        b1.stat_i = 2'b00;
        sample;
        checks++;
        if ({b1.respA_valid, b1.respA_ack, b1.respB_valid, b1.respB_ack} !== 4'b1011) begin
            failures++; $display("FAIL invalid_resp: rvA=%b ackA=%b rvB=%b ackB=%b required 1011",
                                 b1.respA_valid, b1.respA_ack, b1.respB_valid, b1.respB_ack);
        end
        tick;
    endtask

    task automatic test_stat_lat3;
        do_reset();
        tick;
        b3.cmdA_valid = 1'b1; b3.cmdA_data = 32'h2200_1234;
        sample;
        checks++;
        if ({b3.cmdA_ready, b3.busy} !== 2'b10) begin
            failures++; $display("FAIL lat3_accept: readyA=%b busy=%b required 1 0", b3.cmdA_ready, b3.busy);
        end
        tick;
        b3.cmdA_valid = 1'b0;
        sample;
        checks++;
        if ({b3.req_o, b3.busy, b3.ctrlA_o} !== {2'b11, 16'h2200}) begin
            failures++; $display("FAIL lat3_beat0: req=%b busy=%b ctrlA=%h required 1 1 2200",
                                 b3.req_o, b3.busy, b3.ctrlA_o);
        end
        tick;
        tick;
        b3.stat_i = 2'b00;
        tick;
        b3.stat_i = 2'b00;
        tick;
        b3.stat_i = 2'b01;
        sample;
        checks++;
        if ({b3.respA_valid, b3.busy, b3.req_o} !== 3'b010) begin
            failures++; $display("FAIL lat3_last_wait: rvA=%b busy=%b req=%b required 0 1 0",
                                 b3.respA_valid, b3.busy, b3.req_o);
        end
        tick;
        b3.stat_i = 2'b00;
        sample;
        checks++;
        if ({b3.respA_valid, b3.respA_ack, b3.busy} !== 3'b111) begin
            failures++; $display("FAIL lat3_resp: rvA=%b ackA=%b busy=%b required 1 1 1",
                                 b3.respA_valid, b3.respA_ack, b3.busy);
        end
        tick;
        sample;
        checks++;
        if ({b3.respA_valid, b3.busy} !== 2'b00) begin
            failures++; $display("FAIL lat3_idle: rvA=%b busy=%b required 0 0", b3.respA_valid, b3.busy);
        end
    endtask

    task automatic test_reset_mid;
        bit seen_resp = 1'b0;
        do_reset();
        tick;
        b1.cmdA_valid = 1'b1; b1.cmdA_data = 32'h2200_1234;
        tick;
        b1.cmdA_valid = 1'b0;
        tick;
        b1.stat_i = 2'b01;
        reset = 1'b1;
        #1;
        checks++;
        if ({b1.req_o, b1.busy, b1.ctrlA_o, b1.ctrlB_o} !== 34'h0) begin
            failures++; $display("FAIL reset_mid_async: req=%b busy=%b ctrlA=%h ctrlB=%h required all 0",
                                 b1.req_o, b1.busy, b1.ctrlA_o, b1.ctrlB_o);
        end
        tick;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sample;
            if (b1.respA_valid === 1'b1 || b1.respB_valid === 1'b1) seen_resp = 1'b1;
            tick;
        end
        checks++;
        if (seen_resp !== 1'b0) begin
            failures++; $display("FAIL reset_mid_no_resp: response seen=%b required 0", seen_resp);
        end
        b1.stat_i = 2'b00;
        b1.cmdA_valid = 1'b1; b1.cmdA_data = 32'h4400_0001;
        sample;
        checks++;
        if ({b1.cmdA_ready, b1.cmdB_ready} !== 2'b10) begin
            failures++; $display("FAIL reset_mid_next_ready: got %b%b required 10", b1.cmdA_ready, b1.cmdB_ready);
        end
        tick;
        b1.cmdA_valid = 1'b0;
        sample;
        checks++;
        if ({b1.req_o, b1.ctrlA_o} !== {1'b1, 16'h4400}) begin
            failures++; $display("FAIL reset_mid_next_beat0: req=%b ctrlA=%h required 1 4400", b1.req_o, b1.ctrlA_o);
        end
        tick;
        tick;
        b1.stat_i = 2'b01;
        tick;
        b1.stat_i = 2'b00;
        sample;
        checks++;
        if ({b1.respA_valid, b1.respA_ack} !== 2'b11) begin
            failures++; $display("FAIL reset_mid_next_resp: rvA=%b ackA=%b required 1 1", b1.respA_valid, b1.respA_ack);
        end
        tick;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_paired();
        test_conflict_rr();
        test_class_rules();
        test_invalid();
        test_stat_lat3();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ats21_cmd_arbiter.md
# ats21_cmd_arbiter

Two-client command arbiter and sequencer in front of the ATS21 timer core. It accepts 32-bit instructions from client A and client B through valid/ready handshakes. It pairs compatible instructions onto the ATS21 A/B lanes and serializes conflicting ones with round-robin fairness. It drives the ATS21 two-beat `req`/`ctrl` protocol and returns each client's Ack/Nack from the ATS21 `stat` bits.

## Interface
- `STAT_LAT`, default 1: cycles spent in WAIT between the second beat and the `stat_i` sample; legal range 1–7.
- `clk_1x`  in  1  block clock; same clock as the ATS21 reference clock.
- `reset`  in  1  asynchronous, active-high.
- `cmdA_valid`  in  1  client A has an instruction pending.
- `cmdA_data`  in  32  client A instruction; [31:29] is the opcode.
- `cmdA_ready`  out  1  client A instruction accepted this cycle.
- `cmdB_valid`, `cmdB_data`, `cmdB_ready`: same as the A signals, for client B.
- `respA_valid`  out  1  one-cycle pulse; completion for client A.
- `respA_ack`  out  1  1 = Ack, 0 = Nack; qualified by `respA_valid`.
- `respB_valid`, `respB_ack`: same as the A signals, for client B.
- `req_o`  out  1  ATS21 request, high during both beats.
- `ctrlA_o`  out  16  ATS21 lane A: beat 0 = instruction [31:16], beat 1 = [15:0].
- `ctrlB_o`  out  16  ATS21 lane B, same format.
- `stat_i`  in  2  ATS21 status; [0] = lane A, [1] = lane B.
- `busy`  out  1  high in every state except IDLE.

## Operation
- **FSM states:** IDLE → BEAT0 → BEAT1 → WAIT (STAT_LAT cycles) → RESP → IDLE. There are no other transitions except reset.
- **Opcode classes:**
  - Clock class: 001, 010; target index is [28:25].
  - Alarm class: 101, 110, 111; target index is [28:24].
  - Mode: 011.
  - Invalid: 000, 100.
- **Conflict rule:** A and B conflict if any of the following holds:
  - both are clock class with equal [28:25];
  - both are alarm class with equal [28:24] (this includes 101 vs 110);
  - both are 011.
  - Cross-class pairs never conflict.
- **Selection in IDLE:**
  - Only one client valid: select it.
  - Both valid and not conflicting: select both.
  - Both valid and conflicting: select the client named by the round-robin pointer `rr` (0 = A, 1 = B). The loser gets no ready and stays pending. `rr` toggles only on a conflict.
- **Acceptance:** `cmdX_ready` is combinational, asserted in IDLE only for selected lanes. The selected command is latched and the FSM moves to BEAT0. Clients hold valid and data stable until ready.
- **Unused lane:** a lane that is not selected drives `ctrlX_o` = 0 in both beats. The ATS21 ignores a lane whose beat 0 has [15:13] = 0.
- **Invalid opcodes:**
  - Accepted and sequenced like any other command, but the lane drives 0 on both beats.
  - The response is forced to Nack regardless of `stat_i`.
  - An invalid command never conflicts.
- **Status sampling:** `stat_i` is sampled on the clock edge that ends the last WAIT cycle. The lane A bit goes to `respA_ack`, the lane B bit to `respB_ack`.
- **Responses:** in RESP, `respX_valid` pulses only for lanes accepted in this transaction.
- **Reset:** the FSM goes to IDLE, `rr` = 0 and latched commands are cleared. An in-flight transaction is dropped with no response.

## Timing
- **Reset values:** `cmdA_ready`, `cmdB_ready`, `respA_valid`, `respB_valid`, `respA_ack`, `respB_ack`, `req_o`, `ctrlA_o`, `ctrlB_o` and `busy` are all 0.
- **Transaction timeline** (accept in cycle T):
  - `req_o` = 1 in T+1 (beat 0) and T+2 (beat 1).
  - WAIT occupies T+3 … T+2+STAT_LAT.
  - RESP is in T+3+STAT_LAT.
  - The earliest next accept is T+4+STAT_LAT. With STAT_LAT = 1 this is 5 cycles per transaction.
- `req_o` is never high outside BEAT0/BEAT1. `ctrlX_o` is 0 outside those beats.
- `respX_ack` is held from RESP until the next RESP.
- A losing conflicting client is selected in the next IDLE cycle, at T+4+STAT_LAT at the earliest, provided it is still valid.
- A `cmdX_valid` that drops before acceptance is not an error; nothing is issued for it.
- Reset asserted in any state takes effect immediately (asynchronous). All outputs read 0 in the first cycle after reset deasserts.

## Test plan
- **Single command, STAT_LAT = 1:**
  - Stimulus: A sends 0x2200_1234 (set clock 1, rate 0); B is idle; `stat_i` = 01 in T+3.
  - Response: `cmdA_ready` at T; `ctrlA_o` = 0x2200 at T+1 and 0x1234 at T+2; `ctrlB_o` = 0 throughout; `respA_valid` = 1 with `respA_ack` = 1 at T+4; `respB_valid` stays 0.
- **Paired, non-conflicting:**
  - Stimulus: A sends 0x2200_0000 (clock 1), B sends 0xA300_0010 (alarm 3), both in the same cycle; `stat_i` = 11.
  - Response: both readies at T, both lanes driven in the same beats, both responses Ack at T+4.
- **Conflict with round-robin:**
  - Stimulus: both clients send set alarm 5 (0xA500_0020 / 0xC500_0030); this repeats for two transactions.
  - Response: A is served first, B next at T+5; on the following conflict A wins again, because `rr` is back at 0 after two toggles.
- **Invalid opcode:**
  - Stimulus: A sends 0x8000_0000 and B sends a valid clock command; `stat_i` = 11.
  - Response: `ctrlA_o` = 0 in both beats; `respA_ack` = 0, `respB_ack` = 1.
- **STAT_LAT = 3:**
  - Stimulus: single command from A.
  - Response: `stat_i` is sampled at the end of T+5; `respA_valid` at T+6; `busy` is high T+1 … T+6.
- **Reset mid-transaction:**
  - Stimulus: assert `reset` during BEAT1.
  - Response: `req_o` and `ctrlX_o` go to 0 immediately; no `respX_valid` ever appears for that command; the next command is accepted normally.
